// File: rtl/bram_lsu_pkg.sv
// Shared load/store unit definitions: RV32I width codes,
// LSU state encoding and the default BRAM depth.
package bram_lsu_pkg;

  localparam int DEPTH_WORDS_DEF = 1024;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_DATA,
    ST_WR,
    ST_RESP_ERR
  } lsu_state_e;

  // Unsigned widths exist only for loads.
  function automatic logic f3_legal(
    input logic [2:0] f3,
    input logic       we
  );
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] lo
  );
    logic bad;
    case (f3)
      F3_W:        bad = (lo != 2'b00);
      F3_H, F3_HU: bad = lo[0];
      default:     bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extract for loads and lane merge for
// sub-word stores; purely combinational.
module lsu_align
  import bram_lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_word[8*i_addr_lo +: 8];
  assign w_half = i_addr_lo[1] ? i_word[31:16]
                               : i_word[15:0];

  always_comb begin
    o_load = i_word;
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load = {24'b0, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load = {16'b0, w_half};
      default: o_load = i_word;
    endcase
  end

  always_comb begin
    o_merged = i_wdata;
    case (i_funct3)
      F3_B: begin
        o_merged = i_word;
        o_merged[8*i_addr_lo +: 8] = i_wdata[7:0];
      end
      F3_H: begin
        o_merged = i_word;
        o_merged[16*i_addr_lo[1] +: 16] = i_wdata[15:0];
      end
      default: o_merged = i_wdata;
    endcase
  end

endmodule

// File: rtl/bram_lsu.sv
// Load/store unit in front of a 1-cycle synchronous BRAM;
// sub-word stores are done as read-modify-write.
module bram_lsu
  import bram_lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout
);

  localparam logic [31:0] LIMIT = 32'(4 * DEPTH_WORDS);

  lsu_state_e  r_state;
  lsu_state_e  w_next;

  logic        r_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_lo;
  logic [31:0] r_wdata;

  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_din;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  logic        w_acc;
  logic        w_err;
  logic        w_we_n;
  logic [31:0] w_addr_n;
  logic [31:0] w_din_n;
  logic        w_rv_n;
  logic        w_err_n;
  logic [31:0] w_rd_n;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign req_ready  = (r_state == ST_IDLE);
  assign w_acc      = req_valid && req_ready;
  assign w_err      = !f3_legal(req_funct3, req_we)
                   || misaligned(req_funct3, req_addr[1:0])
                   || (req_addr >= LIMIT);

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_din    = r_mem_din;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

  lsu_align u_align (
    .i_funct3  (r_f3),
    .i_addr_lo (r_lo),
    .i_word    (mem_dout),
    .i_wdata   (r_wdata),
    .o_load    (w_load),
    .o_merged  (w_merged)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          if (w_err)
            w_next = ST_RESP_ERR;
          else if (req_we && req_funct3 == F3_W)
            w_next = ST_WR;
          else
            w_next = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: w_next = ST_RD_DATA;
      ST_RD_DATA:  w_next = r_we ? ST_WR : ST_IDLE;
      ST_WR:       w_next = ST_IDLE;
      ST_RESP_ERR: w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_we_n   = 1'b0;
    w_rv_n   = 1'b0;
    w_err_n  = 1'b0;
    w_rd_n   = '0;
    w_addr_n = r_mem_addr;
    w_din_n  = r_mem_din;
    unique case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          if (w_err) begin
            w_rv_n  = 1'b1;
            w_err_n = 1'b1;
          end else begin
            w_addr_n = {req_addr[31:2], 2'b00};
            if (req_we && req_funct3 == F3_W) begin
              w_we_n  = 1'b1;
              w_din_n = req_wdata;
            end
          end
        end
      end
      ST_RD_DATA: begin
        if (r_we) begin
          w_we_n  = 1'b1;
          w_din_n = w_merged;
        end else begin
          w_rv_n = 1'b1;
          w_rd_n = w_load;
        end
      end
      ST_WR:   w_rv_n = 1'b1;
      default: w_rv_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_we         <= 1'b0;
      r_f3         <= '0;
      r_lo         <= '0;
      r_wdata      <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      if (w_acc) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_lo    <= req_addr[1:0];
        r_wdata <= req_wdata;
      end
      r_mem_we     <= w_we_n;
      r_mem_addr   <= w_addr_n;
      r_mem_din    <= w_din_n;
      r_resp_valid <= w_rv_n;
      r_resp_err   <= w_err_n;
      r_resp_rdata <= w_rd_n;
    end
  end

endmodule

// File: tb/tb_bram_lsu.sv
// Bench for bram_lsu: directed cases, reset aborts and
// random traffic against a word-array reference model.
module tb_bram_lsu;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  logic        clr;
  logic [31:0] bram [DEPTH];
  logic [31:0] refm [DEPTH];

  int total = 0;
  int bad   = 0;

  bram_lsu #(.DEPTH_WORDS(DEPTH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read BRAM, read-before-write.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) bram[i] <= '0;
    end else begin
      if (mem_we) bram[mem_addr[11:2]] <= mem_din;
      mem_dout <= bram[mem_addr[11:2]];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic        we,
                        input logic [2:0]  f3,
                        input logic [31:0] addr,
                        input logic [31:0] wdata);
    logic        e;
    int          lat, wcyc, idx, sh;
    logic [31:0] word, v, mask, nw;
    int          got, nresp, nwe, we_at;
    logic        r_err;
    logic [31:0] r_rd, we_a, we_d;
    e = 1'b0;
    if (f3 == 3 || f3 >= 6) e = 1'b1;
    if (we && (f3 == 4 || f3 == 5)) e = 1'b1;
    if (f3 == 2 && addr[1:0] != 0) e = 1'b1;
    if ((f3 == 1 || f3 == 5) && addr[0]) e = 1'b1;
    if (addr >= 4 * DEPTH) e = 1'b1;
    lat = 1; wcyc = 0; v = 0; nw = 0; idx = 0;
    if (!e) begin
      idx  = int'(addr / 4);
      word = refm[idx];
      if (!we) begin
        lat = 3;
        if (f3 == 0 || f3 == 4) begin
          v = (word >> (addr % 4 * 8)) & 32'hFF;
          if (f3 == 0 && v >= 128) v = v + 32'hFFFFFF00;
        end else if (f3 == 1 || f3 == 5) begin
          v = (word >> (addr % 4 / 2 * 16)) & 32'hFFFF;
          if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
        end else begin
          v = word;
        end
      end else if (f3 == 2) begin
        lat = 2; wcyc = 1; nw = wdata;
      end else begin
        lat = 4; wcyc = 3;
        sh   = (f3 == 0) ? int'(addr % 4 * 8)
                         : int'(addr % 4 / 2 * 16);
        mask = ((f3 == 0) ? 32'hFF : 32'hFFFF) << sh;
        nw   = (word & ~mask) | ((wdata << sh) & mask);
      end
    end
    @(negedge clk);
    chk("ready", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    got = 0; nresp = 0; nwe = 0; we_at = 0;
    r_err = 1'b0; r_rd = '0; we_a = '0; we_d = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (mem_we) begin
        nwe++; we_at = k; we_a = mem_addr; we_d = mem_din;
      end
      if (resp_valid) begin
        nresp++;
        if (got == 0) begin
          got = k; r_err = resp_err; r_rd = resp_rdata;
        end
      end
    end
    chk("resp_lat", 32'(got), 32'(lat));
    chk("resp_cnt", 32'(nresp), 32'd1);
    chk("resp_err", {31'b0, r_err}, {31'b0, e});
    chk("resp_rdata", r_rd, v);
    chk("we_cnt", 32'(nwe), (wcyc != 0) ? 32'd1 : 32'd0);
    if (wcyc != 0) begin
      chk("we_cycle", 32'(we_at), 32'(wcyc));
      chk("we_addr", we_a, {addr[31:2], 2'b00});
      chk("we_din", we_d, nw);
      refm[idx] = nw;
    end
  endtask

  initial begin
    logic [31:0] d [3];
    int          wc [3];
    int          rc [3];
    logic [31:0] wa [3];
    int          nw, nr, issued, nbad;

    for (int i = 0; i < DEPTH; i++) refm[i] = '0;
    rstn = 1'b0; clr = 1'b1;
    req_valid = 1'b1; req_we = 1'b1;
    req_funct3 = 3'd2; req_addr = 32'h40;
    req_wdata = 32'h12345678;
    @(posedge clk);
    @(posedge clk);
    clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rstn = 1'b1;

    // Directed: first request right after reset release.
    run_op(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    run_op(1'b0, 3'd0, 32'h13, 32'h0);
    chk("lb_model", refm[4], 32'hDEADBEEF);
    run_op(1'b0, 3'd4, 32'h12, 32'h0);
    run_op(1'b0, 3'd5, 32'h10, 32'h0);
    run_op(1'b1, 3'd0, 32'h11, 32'h55);
    chk("sb_bram", bram[4], 32'hDEAD55EF);
    run_op(1'b0, 3'd2, 32'h12, 32'h0);
    run_op(1'b1, 3'd1, 32'h13, 32'hAAAA);
    run_op(1'b0, 3'd2, 32'h1000, 32'h0);
    run_op(1'b0, 3'd3, 32'h10, 32'h0);
    run_op(1'b1, 3'd4, 32'h10, 32'h0);
    run_op(1'b0, 3'd2, 32'hFFC, 32'h0);

    // Back-to-back stores with req_valid held high.
    d[0] = $urandom; d[1] = $urandom; d[2] = $urandom;
    nw = 0; nr = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h30; req_wdata = d[0];
    issued = 1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_we) begin
        if (nw < 3) begin
          wc[nw] = c; wa[nw] = mem_addr;
        end
        nw++;
      end
      if (resp_valid) begin
        if (nr < 3) rc[nr] = c;
        nr++;
        if (issued < 3) begin
          req_addr  = 32'h30 + 32'(4 * issued);
          req_wdata = d[issued];
          issued++;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    chk("b2b_we_cnt", 32'(nw), 32'd3);
    chk("b2b_resp_cnt", 32'(nr), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < nw) begin
        chk("b2b_we_cycle", 32'(wc[i]), 32'(2 * i + 1));
        chk("b2b_we_addr", wa[i], 32'h30 + 32'(4 * i));
      end
      if (i < nr) chk("b2b_resp_cycle", 32'(rc[i]), 32'(2 * i + 2));
      refm[12 + i] = d[i];
    end
    run_op(1'b0, 3'd2, 32'h34, 32'h0);

    // Reset during RD_DATA of an sh: no write, no response.
    run_op(1'b1, 3'd2, 32'h20, 32'hCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd1;
    req_addr = 32'h22; req_wdata = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("abort_rd_we", {31'b0, mem_we}, 32'd0);
    chk("abort_rd_rv", {31'b0, resp_valid}, 32'd0);
    @(posedge clk);
    #2 rstn = 1'b1;
    nbad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem_we || resp_valid) nbad++;
    end
    chk("abort_rd_quiet", 32'(nbad), 32'd0);
    chk("abort_rd_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_rd_bram", bram[8], 32'hCAFEF00D);
    run_op(1'b0, 3'd2, 32'h20, 32'h0);

    // Reset while the sw write strobe is high.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h24; req_wdata = 32'h0BADC0DE;
    @(posedge clk);
    #2 rstn = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("abort_wr_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk);
    #2 rstn = 1'b1;
    run_op(1'b0, 3'd2, 32'h24, 32'h0);

    // Random traffic.
    for (int n = 0; n < 200; n++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      int          sel;
      sel = int'($urandom_range(0, 15));
      if (sel == 0) f3 = 3'($urandom_range(0, 7));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0;
          1: f3 = 3'd1;
          2: f3 = 3'd2;
          3: f3 = 3'd4;
          default: f3 = 3'd5;
        endcase
      end
      sel = int'($urandom_range(0, 15));
      if (sel == 0) a = $urandom;
      else if (sel < 3)
        a = 32'(4 * DEPTH - 8) + 32'($urandom_range(0, 15));
      else a = 32'($urandom_range(0, 63));
      run_op(1'($urandom_range(0, 1)), f3, a, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
